// File: rtl/fetch_stage_pkg.sv
// Shared myCPU bus widths used by the instruction fetch stage.
package fetch_stage_pkg;

    localparam int IF_TO_IPD_BUS_WD = 96;
    localparam int ID_TO_IF_BUS_WD  = 33;
    localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction SRAM, holds one stalled
// instruction in a depth-1 buffer and honours taken-branch redirects from decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ID_TO_IF_BUS_WD-1:0]  ID_to_IF_bus,
    input  logic                        IPD_allow_in,
    output logic                        IF_to_IPD_valid,
    output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
    output logic                        inst_sram_en,
    output logic [31:0]                 inst_sram_addr,
    input  logic [31:0]                 inst_sram_rdata
);

    logic        br_taken_cancel;
    logic [31:0] PC_fromID;
    logic [31:0] seq_pc;
    logic [31:0] IF_pc;
    logic        IF_valid;
    logic [31:0] inst_buf;
    logic        buf_valid;
    logic        IF_allow_in;
    logic        fetch_fire;
    logic [31:0] fetch_pc;
    logic [31:0] inst;

    assign {br_taken_cancel, PC_fromID} = ID_to_IF_bus;

    assign IF_allow_in = ~IF_valid | IPD_allow_in;
    assign fetch_pc    = br_taken_cancel ? PC_fromID : seq_pc;
    assign fetch_fire  = ~reset & (br_taken_cancel | IF_allow_in);

    assign inst_sram_en   = fetch_fire;
    assign inst_sram_addr = fetch_pc;

    // SRAM data is only live the cycle after the read, so a stalled instruction
    // must come from the buffer on every later cycle.
    assign inst            = buf_valid ? inst_buf : inst_sram_rdata;
    assign IF_to_IPD_valid = IF_valid & ~br_taken_cancel;
    assign IF_to_IPD_bus   = {IF_pc + INST_BYTES, IF_pc, inst};

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_pc   <= RESET_PC;
            IF_pc    <= 32'd0;
            IF_valid <= 1'b0;
        end else if (fetch_fire) begin
            IF_pc    <= fetch_pc;
            seq_pc   <= fetch_pc + INST_BYTES;
            IF_valid <= 1'b1;
        end else if (IPD_allow_in && IF_valid) begin
            IF_valid <= 1'b0;
        end
    end

    // A redirect discards the buffered instruction even while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_buf  <= 32'd0;
            buf_valid <= 1'b0;
        end else if (br_taken_cancel || IPD_allow_in) begin
            buf_valid <= 1'b0;
        end else if (IF_valid && !buf_valid) begin
            inst_buf  <= inst_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: ID_to_IF_bus  input  33  {br_taken_cancel[32], PC_fromID[31:0]}; redirect request from decode.
REQ-005 SHALL have port: IPD_allow_in  input  1  downstream pre-decode stage can accept this cycle.
REQ-006 SHALL have port: IF_to_IPD_valid  output  1  IF_to_IPD_bus holds a live instruction.
REQ-007 SHALL have port: IF_to_IPD_bus  output  96  {pred_PC[95:64], inst_PC[63:32], inst[31:0]}.
REQ-008 SHALL have port: inst_sram_en  output  1  instruction SRAM read enable.
REQ-009 SHALL have port: inst_sram_addr  output  32  read byte address.
REQ-010 SHALL have port: inst_sram_rdata  input  32  read data, valid exactly one cycle after an enabled read.

Function
REQ-011 SHALL keep state: seq_pc (next sequential fetch address), IF_pc, IF_valid, inst_buf[31:0], buf_valid.
REQ-012 SHALL compute IF_allow_in = ~IF_valid | IPD_allow_in (ready_go fixed at 1).
REQ-013 SHALL compute fetch_pc = br_taken_cancel ? PC_fromID : seq_pc.
REQ-014 SHALL compute fetch_fire = ~reset & (br_taken_cancel | IF_allow_in); inst_sram_en = fetch_fire; inst_sram_addr = fetch_pc.
REQ-015 SHALL, on fetch_fire, load IF_pc <= fetch_pc, seq_pc <= fetch_pc + 4 (modulo 2^32, 32'hfffffffc wraps to 0), IF_valid <= 1.
REQ-016 SHALL, when not fetch_fire and IPD_allow_in and IF_valid, clear IF_valid (not reachable by REQ-012, kept for completeness); otherwise hold IF state.
REQ-017 SHALL drive inst = buf_valid ? inst_buf : inst_sram_rdata; inst_PC = IF_pc; pred_PC = IF_pc + 4 (static not-taken prediction).
REQ-018 SHALL drive IF_to_IPD_valid = IF_valid & ~br_taken_cancel.
REQ-019 SHALL capture inst_buf <= inst_sram_rdata and set buf_valid when IF_valid & ~IPD_allow_in & ~buf_valid & ~br_taken_cancel.
REQ-020 SHALL clear buf_valid when IPD_allow_in or br_taken_cancel; cancel has priority over capture.
REQ-021 SHALL, on br_taken_cancel, discard the current IF instruction and buffer regardless of IPD_allow_in and fetch PC_fromID in the same cycle; redirected instruction presented with IF_to_IPD_valid one cycle later.
REQ-022 SHALL provide 1-cycle latency from fetch_fire to IF_to_IPD_valid; throughput one instruction/cycle when IPD_allow_in stays 1.
REQ-023 SHALL never issue a second SRAM read while a presented instruction is stalled (buffer depth 1 suffices).
REQ-024 SHALL not check alignment of PC_fromID; address passed unchanged.

Reset
REQ-025 SHALL, while reset=1, set seq_pc=RESET_PC, IF_pc=0, IF_valid=0, inst_buf=0, buf_valid=0, inst_sram_en=0, IF_to_IPD_valid=0.
REQ-026 SHALL fetch RESET_PC in the first cycle after reset deasserts; reset asserted mid-stall or mid-redirect SHALL discard all in-flight state.

Structure
REQ-027 SHALL take IF_TO_IPD_BUS_WD (96) and ID_TO_IF_BUS_WD (33) from the shared myCPU header; RESET_PC stays a module parameter.
REQ-028 SHALL be a single module with no sub-modules.

Verification
REQ-029 Reset release, IPD_allow_in=1, SRAM returns addr-as-data -> sram addrs 1c000000,1c000004,1c000008 consecutive; bus inst_PC 1c000000 next cycle, pred_PC 1c000004, valid every cycle.
REQ-030 Stall: IPD_allow_in=0 for 3 cycles while inst_PC=1c000004 valid, rdata changes to 0xdeadbeef after first cycle -> inst stays 1c000004 data, inst_sram_en=0, no PC advance; resume -> next fetch 1c000008.
REQ-031 Redirect: br_taken_cancel=1, PC_fromID=1c000100 with IPD_allow_in=0 -> inst_sram_en=1, addr 1c000100, IF_to_IPD_valid=0 that cycle; next cycle inst_PC=1c000100 valid, buf_valid=0.
REQ-032 Cancel while buffer full -> buffered instruction never presented; redirected instruction presented next cycle.
REQ-033 RESET_PC=32'hfffffffc -> fetches fffffffc then 00000000; pred_PC of first = 00000000.
REQ-034 Reset asserted during stall -> valid drops same edge; after release first fetch is RESET_PC.
